// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Boot-time program loader acting as the write port of the instruction
//   memory. A byte stream (valid/ready) carries a 32-bit little-endian word
//   count, that many little-endian instruction words, and finally a 32-bit
//   XOR checksum of those words. Each completed word is written to
//   consecutive word addresses starting at BASE_ADDR. The processor is held
//   in reset until the whole image has arrived and the checksum matches.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   start         : re-arm pulse, honoured only in DONE or ERROR
//   byte_valid    : byte_data carries a byte
//   byte_data     : stream byte
//   byte_ready    : loader accepts a byte this cycle
//   imem_we       : one-cycle write strobe to instruction memory
//   imem_waddr    : word-aligned byte address of the write
//   imem_wdata    : word being written
//   cpu_rst_hold  : holds the processor in reset while high
//   load_done     : image loaded and checksum matched
//   load_error    : oversize length or checksum mismatch
//   words_loaded  : words written during the current load
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst_hold,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    localparam logic [31:0] MAX_LEN = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_LEN   = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [1:0]  byte_cnt;
    logic [23:0] asm_reg;     // lanes 0..2 of the group in progress
    logic [31:0] length;
    logic [31:0] checksum;
    logic [15:0] word_idx;

    logic        accept;
    logic        group_done;
    logic [31:0] word;
    logic [31:0] idx_next;
    logic        rearm;

    assign accept     = byte_valid & byte_ready;
    assign group_done = accept && (byte_cnt == 2'd3);
    // The 4th byte is used straight from the input so the completed word is
    // available on the same edge that accepts it.
    assign word       = {byte_data, asm_reg};
    assign idx_next   = {16'd0, word_idx} + 32'd1;
    assign rearm      = start && ((state == S_DONE) || (state == S_ERROR));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_LEN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_LEN: begin
                if (group_done) begin
                    if (word > MAX_LEN) begin
                        state_nxt = S_ERROR;
                    end else if (word == 32'd0) begin
                        state_nxt = S_CHECK;
                    end else begin
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (group_done && (idx_next == length)) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (group_done) begin
                    state_nxt = (word == checksum) ? S_DONE : S_ERROR;
                end
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    state_nxt = S_LEN;
                end
            end
            default: state_nxt = S_LEN;
        endcase
    end

    // Output decode; every output is a function of registered state only,
    // so byte_ready never depends on byte_valid.
    always_comb begin
        byte_ready   = 1'b0;
        cpu_rst_hold = 1'b1;
        load_done    = 1'b0;
        load_error   = 1'b0;
        case (state)
            S_LEN, S_LOAD, S_CHECK: byte_ready = 1'b1;
            S_DONE: begin
                cpu_rst_hold = 1'b0;
                load_done    = 1'b1;
            end
            S_ERROR: load_error = 1'b1;
            default: ;
        endcase
    end

    // Byte assembly, counters, checksum and the memory write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt     <= 2'd0;
            asm_reg      <= 24'd0;
            length       <= 32'd0;
            checksum     <= 32'd0;
            word_idx     <= 16'd0;
            words_loaded <= 16'd0;
            imem_we      <= 1'b0;
            imem_waddr   <= BASE_ADDR;
            imem_wdata   <= 32'd0;
        end else begin
            imem_we <= 1'b0;

            if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0:    asm_reg[7:0]   <= byte_data;
                    2'd1:    asm_reg[15:8]  <= byte_data;
                    2'd2:    asm_reg[23:16] <= byte_data;
                    default: ;
                endcase
            end

            if (group_done && (state == S_LEN)) begin
                length <= word;
            end

            if (group_done && (state == S_LOAD)) begin
                imem_we      <= 1'b1;
                imem_wdata   <= word;
                imem_waddr   <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                checksum     <= checksum ^ word;
                word_idx     <= word_idx + 16'd1;
                words_loaded <= words_loaded + 16'd1;
            end

            // No byte can be accepted in DONE/ERROR, so this never collides
            // with the assembly updates above.
            if (rearm) begin
                byte_cnt     <= 2'd0;
                checksum     <= 32'd0;
                word_idx     <= 16'd0;
                words_loaded <= 16'd0;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int MAXW = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_rst_hold;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .cpu_rst_hold(cpu_rst_hold), .load_done(load_done),
        .load_error(load_error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passed = 0;
    logic [63:0] exp_q[$];   // expected writes {addr, data}
    logic [31:0] img[$];     // image words for the next load
    logic [63:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write",
                         imem_waddr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write_addr", imem_waddr, mon_e[63:32]);
                chk("write_data", imem_wdata, mon_e[31:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            while ($urandom_range(1, 0) == 1) begin
                byte_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (byte_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 20) begin
            checks++;
            $display("FAIL byte_ready_timeout: got byte_ready=%b expected 1 within 20 cycles", byte_ready);
        end else begin
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
    endtask

    task automatic pulse_start(input string name);
        // byte_valid is raised together with start: the byte must be dropped.
        start = 1'b1; byte_valid = 1'b1; byte_data = 8'hA5;
        @(posedge clk); #1;
        start = 1'b0; byte_valid = 1'b0;
        chk({name, "_rearm_done"},  load_done, 0);
        chk({name, "_rearm_err"},   load_error, 0);
        chk({name, "_rearm_words"}, words_loaded, 0);
        chk({name, "_rearm_hold"},  cpu_rst_hold, 1);
        chk({name, "_rearm_ready"}, byte_ready, 1);
    endtask

    // Reference model: writes happen only for an in-range length; success
    // iff the supplied checksum equals the XOR of the image words.
    task automatic run_load(input logic [31:0] len, input logic [31:0] csum,
                            input bit gaps, input bit do_start, input string name);
        logic [31:0] x;
        int          nw;
        bit          err;
        x = 32'd0;
        if (len > 32'(MAXW)) begin
            err = 1'b1; nw = 0;
        end else begin
            nw = int'(len);
            for (int i = 0; i < nw; i++) x ^= img[i];
            err = (x != csum);
        end
        for (int i = 0; i < nw; i++) exp_q.push_back({32'(i * 4), img[i]});
        send_word(len, gaps);
        if (len <= 32'(MAXW)) begin
            for (int i = 0; i < nw; i++) send_word(img[i], gaps);
            send_word(csum, gaps);
        end
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_done"},    load_done, {31'd0, !err});
        chk({name, "_error"},   load_error, {31'd0, err});
        chk({name, "_hold"},    cpu_rst_hold, {31'd0, err});
        chk({name, "_ready"},   byte_ready, 0);
        chk({name, "_words"},   words_loaded, 32'(nw));
        chk({name, "_pending"}, exp_q.size(), 0);
        if (do_start) pulse_start(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] cs;
        int          nw;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", imem_we, 0);
        chk("rst_waddr", imem_waddr, 32'h0);
        chk("rst_wdata", imem_wdata, 32'h0);
        chk("rst_hold", cpu_rst_hold, 1);
        chk("rst_done", load_done, 0);
        chk("rst_error", load_error, 0);
        chk("rst_words", words_loaded, 0);
        chk("rst_ready", byte_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero length, checksum 0 -> DONE, then asynchronous reset mid-cycle
        img.delete();
        run_load(32'd0, 32'd0, 1'b0, 1'b0, "zero_ok");
        @(posedge clk); #4;
        rst = 1'b1;
        #1;
        chk("async_hold", cpu_rst_hold, 1);
        chk("async_ready", byte_ready, 1);
        chk("async_done", load_done, 0);
        chk("async_we", imem_we, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Nominal load
        img = '{32'h2001_0005, 32'h2002_000A, 32'h0022_1820};
        run_load(32'd3, 32'h2001_0005 ^ 32'h2002_000A ^ 32'h0022_1820, 1'b0, 1'b1, "nominal");

        // Bad checksum
        run_load(32'd3, 32'h0000_0000, 1'b0, 1'b1, "bad_csum");

        // Oversize length
        run_load(32'(MAXW + 1), 32'h0, 1'b0, 1'b1, "oversize");

        // Zero length with checksum 1
        img.delete();
        run_load(32'd0, 32'd1, 1'b0, 1'b1, "zero_bad");

        // Nominal with random gaps
        img = '{32'h2001_0005, 32'h2002_000A, 32'h0022_1820};
        run_load(32'd3, 32'h2001_0005 ^ 32'h2002_000A ^ 32'h0022_1820, 1'b1, 1'b1, "gappy");

        // Reset after 6 data bytes: only the first word is written
        exp_q.push_back({32'h0, img[0]});
        send_word(32'd3, 1'b0);
        send_word(img[0], 1'b0);
        send_byte(img[1][7:0], 1'b0);
        send_byte(img[1][15:8], 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_ready", byte_ready, 1);
        chk("midrst_hold", cpu_rst_hold, 1);
        chk("midrst_words", words_loaded, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_pending", exp_q.size(), 0);
        run_load(32'd3, 32'h2001_0005 ^ 32'h2002_000A ^ 32'h0022_1820, 1'b0, 1'b1, "after_rst");

        // Randomized images
        for (int t = 0; t < 8; t++) begin
            img.delete();
            nw = $urandom_range(8, 1);
            cs = 32'd0;
            for (int i = 0; i < nw; i++) begin
                img.push_back($urandom());
                cs ^= img[i];
            end
            if ($urandom_range(3, 0) == 0) cs ^= (32'd1 << $urandom_range(31, 0));
            if (t == 7) run_load(32'($urandom_range(2000, MAXW + 1)), cs, 1'b1, 1'b1, "rand_big");
            else        run_load(32'(nw), cs, $urandom_range(1, 0) == 1, 1'b1, "rand");
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
